gpu_hw_ctrl_regs_dbuf: RTL and testbench
========================================

GPU_HW_CTRL_REGS_DBUF -- requirements
Module: gpu_hw_ctrl_regs_dbuf

Interface
REQ-001 SHALL provide parameter ADDR_W, default 20, meaning bus address width.
REQ-002 SHALL provide parameter DATA_W, default 8, meaning register width.
REQ-003 SHALL provide parameter REGS_BITS, default 8, meaning register count N = 2**REGS_BITS.
REQ-004 SHALL provide parameter BASE_ADDR, default 0, meaning block base; only bits [ADDR_W-1:REGS_BITS] are compared.
REQ-005 SHALL provide parameter NUM_RST, default 32, meaning registers 0..NUM_RST-1 take a table reset value.
REQ-006 SHALL provide parameter RST_VALUES, a NUM_RST-entry table with default entry i = i+1, meaning the reset value of register i.
REQ-007 SHALL have port clk, input, 1 bit: clock; all logic is rising-edge.
REQ-008 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-009 SHALL have port we, input, 1 bit: write strobe.
REQ-010 SHALL have port addr_in, input, ADDR_W bits: bus address.
REQ-011 SHALL have port data_in, input, DATA_W bits: write data.
REQ-012 SHALL have port vsync, input, 1 bit: vertical sync, synchronous to clk.
REQ-013 SHALL have port regs_active, output, N x DATA_W: the committed bank driving the display hardware.
REQ-014 SHALL have port data_out, output, DATA_W bits: registered read data.
REQ-015 SHALL have port commit_pending, output, 1 bit: a commit is armed.
REQ-016 SHALL have port commit_pulse, output, 1 bit: one-cycle strobe marking the cycle the active bank updates.

Function
REQ-017 SHALL assert hit when addr_in[ADDR_W-1:REGS_BITS] == BASE_ADDR[ADDR_W-1:REGS_BITS]; idx = addr_in[REGS_BITS-1:0].
REQ-018 SHALL write data_in into shadow[idx] on each clock edge with we && hit && idx != N-1; regs_active is never written directly by the bus.
REQ-019 SHALL treat idx N-1 as CTRL: a write with data_in[0]=1 arms a commit; a write with data_in[1]=1 requests an immediate commit; shadow[N-1] is not stored, and regs_active[N-1] is constant 0.
REQ-020 SHALL run a 2-state FSM: IDLE -> ARMED on an arm write; ARMED -> IDLE on the commit edge; commit_pending = (state == ARMED).
REQ-021 SHALL register vsync once (vsync_d); the commit edge is the cycle where vsync && !vsync_d while in ARMED.
REQ-022 SHALL, on that edge, copy shadow[0..N-2] into regs_active; new values become visible on the following cycle, and commit_pulse is high for exactly that one cycle.
REQ-023 SHALL perform the same copy on the cycle after an immediate-commit write, independent of vsync, then go to IDLE.
REQ-024 SHALL, when a shadow write coincides with the copy cycle, copy the pre-write shadow value; the written value lands in shadow only and waits for the next commit.
REQ-025 SHALL let an arm write on the commit-edge cycle win: the FSM stays or returns to ARMED, and the copy still occurs.
REQ-026 SHALL ignore repeated arm writes while in ARMED; no queueing and no second commit occur.
REQ-027 SHALL ignore a vsync rising edge while in IDLE; regs_active stays unchanged.
REQ-028 SHALL produce data_out with 1-cycle latency: shadow[idx] when hit and idx != N-1; {0, commit_pending} when idx == N-1; 0 when !hit. A read returns the value before any same-cycle write.

Reset
REQ-029 SHALL, while rst is high, set shadow[i] and regs_active[i] to RST_VALUES[i][DATA_W-1:0] for i < NUM_RST, and 0 otherwise.
REQ-030 SHALL, while rst is high, set state to IDLE and clear vsync_d, data_out, and commit_pulse.
REQ-031 SHALL give rst priority over writes and commits; a commit armed before reset is discarded.

Verification
REQ-032 SHALL cover the reset test: pulse rst -> regs_active[0]=0x01, [31]=0x20, [32]=0x00; read of addr 5 returns 0x06 one cycle later.
REQ-033 SHALL cover staging: write 0xAA to reg 3 -> regs_active[3] stays 0x04; write CTRL=0x01, then vsync rises -> commit_pulse fires once and regs_active[3]=0xAA on the next cycle.
REQ-034 SHALL cover the vsync-only case: vsync toggles with nothing armed -> no commit_pulse and regs_active is unchanged.
REQ-035 SHALL cover collision: write 0x55 to reg 7 on the commit-edge cycle -> regs_active[7] keeps the old shadow value, shadow[7]=0x55, and a read of CTRL returns 0x00.
REQ-036 SHALL cover immediate commit: write CTRL=0x02 -> commit_pulse occurs one cycle later with no vsync.
REQ-037 SHALL cover address decode: with BASE_ADDR=0x100, a write to 0x00203 -> no state change, and a read of it returns 0.

Source files
------------

// File: rtl/gpu_hw_ctrl_regs_dbuf.sv
`default_nettype none
// ============================================================================
// Module   : gpu_hw_ctrl_regs_dbuf
// Purpose  : Double-buffered display control register file. The bus writes a
//            shadow bank. The shadow bank is copied into the active bank
//            (regs_active) that drives the display hardware. The copy
//            happens either on the first vsync rising edge after a commit has
//            been armed, or right away after an immediate-commit request.
//            The top register index (N-1) is a control register, not storage.
// Ports    : clk, rst         - rising-edge clock, synchronous active-high reset
//            we, addr_in,     - bus write strobe, address and write data
//            data_in
//            vsync            - vertical sync, already synchronous to clk
//            regs_active      - committed bank, N x DATA_W (entry N-1 is 0)
//            data_out         - registered read data, 1-cycle latency
//            commit_pending   - a commit is armed and waiting for vsync
//            commit_pulse     - high for the first cycle new values are visible
// Revision : 1.0 - initial release
// ============================================================================
module gpu_hw_ctrl_regs_dbuf #(
    parameter int                ADDR_W    = 20,
    parameter int                DATA_W    = 8,
    parameter int                REGS_BITS = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                NUM_RST   = 32,
    parameter logic [31:0]       RST_VALUES [NUM_RST] = '{
        32'd1,  32'd2,  32'd3,  32'd4,  32'd5,  32'd6,  32'd7,  32'd8,
        32'd9,  32'd10, 32'd11, 32'd12, 32'd13, 32'd14, 32'd15, 32'd16,
        32'd17, 32'd18, 32'd19, 32'd20, 32'd21, 32'd22, 32'd23, 32'd24,
        32'd25, 32'd26, 32'd27, 32'd28, 32'd29, 32'd30, 32'd31, 32'd32
    }
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 we,
    input  logic [ADDR_W-1:0]                    addr_in,
    input  logic [DATA_W-1:0]                    data_in,
    input  logic                                 vsync,
    output logic [2**REGS_BITS-1:0][DATA_W-1:0]  regs_active,
    output logic [DATA_W-1:0]                    data_out,
    output logic                                 commit_pending,
    output logic                                 commit_pulse
);

    localparam int                   c_n        = 2**REGS_BITS;
    localparam logic [REGS_BITS-1:0] c_ctrl_idx = '1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic                            r_vsync_d;

    logic                            w_hit;
    logic [REGS_BITS-1:0]            w_idx;
    logic                            w_wr_shadow;
    logic                            w_wr_ctrl;
    logic                            w_arm;
    logic                            w_imm;
    logic                            w_vsync_rise;
    logic                            w_copy;
    logic [c_n-1:0][DATA_W-1:0]      w_shadow_all;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign w_hit       = (addr_in[ADDR_W-1:REGS_BITS] == BASE_ADDR[ADDR_W-1:REGS_BITS]);
    assign w_idx       = addr_in[REGS_BITS-1:0];
    assign w_wr_shadow = we && w_hit && (w_idx != c_ctrl_idx);
    assign w_wr_ctrl   = we && w_hit && (w_idx == c_ctrl_idx);
    assign w_arm       = w_wr_ctrl && data_in[0];
    assign w_imm       = w_wr_ctrl && data_in[1];

    assign w_vsync_rise = vsync && !r_vsync_d;

    // A single copy strobe covers both the armed vsync edge and an immediate
    // request. If both happen in the same cycle, only one copy is made.
    assign w_copy = ((r_state == ST_ARMED) && w_vsync_rise) || w_imm;

    // ------------------------------------------------------------------
    // Commit FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // An arm write takes priority over the copy that ends the current
    // commit, so a re-arm on the commit edge leaves the FSM armed.
    always_comb begin
        w_state_nxt = r_state;
        if (w_arm) begin
            w_state_nxt = ST_ARMED;
        end else if (w_copy) begin
            w_state_nxt = ST_IDLE;
        end
    end

    assign commit_pending = (r_state == ST_ARMED);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vsync_d    <= 1'b0;
            commit_pulse <= 1'b0;
        end else begin
            r_vsync_d    <= vsync;
            commit_pulse <= w_copy;
        end
    end

    // ------------------------------------------------------------------
    // Shadow and active banks, one slice per storage register
    // ------------------------------------------------------------------
    for (genvar i = 0; i < c_n - 1; i++) begin : g_reg
        logic [DATA_W-1:0] w_rst_val;
        logic [DATA_W-1:0] r_shadow;
        logic [DATA_W-1:0] r_active;

        if (i < NUM_RST) begin : g_tbl
            assign w_rst_val = RST_VALUES[i][DATA_W-1:0];
        end else begin : g_zero
            assign w_rst_val = '0;
        end

        // Both banks update on the same edge. Because the assignments are
        // non-blocking, a shadow write that coincides with a copy is not
        // included in that copy. It stays in the shadow bank until the
        // next commit.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_shadow <= w_rst_val;
                r_active <= w_rst_val;
            end else begin
                if (w_wr_shadow && (w_idx == REGS_BITS'(i))) begin
                    r_shadow <= data_in;
                end
                if (w_copy) begin
                    r_active <= r_shadow;
                end
            end
        end

        assign w_shadow_all[i] = r_shadow;
        assign regs_active[i]  = r_active;
    end

    // The control slot has no storage behind it.
    assign w_shadow_all[c_n-1] = '0;
    assign regs_active[c_n-1]  = '0;

    // ------------------------------------------------------------------
    // Registered read port
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
        end else if (!w_hit) begin
            data_out <= '0;
        end else if (w_idx == c_ctrl_idx) begin
            data_out <= {{(DATA_W-1){1'b0}}, commit_pending};
        end else begin
            data_out <= w_shadow_all[w_idx];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gpu_hw_ctrl_regs_dbuf.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpu_hw_ctrl_regs_dbuf
// Purpose  : Scoreboard bench for gpu_hw_ctrl_regs_dbuf. Directed stimulus
//            pushes hand-computed expectations into queues. A negedge monitor
//            pops them when the DUT presents a read result or a commit pulse,
//            or when a state probe is strobed. Instance dut uses the default
//            base address; dut_b uses base 0x100 to exercise address decode.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpu_hw_ctrl_regs_dbuf;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              we = 1'b0;
    logic [19:0]       addr_in = '0;
    logic [7:0]        data_in = '0;
    logic              vsync = 1'b0;

    logic [255:0][7:0] active_a, active_b;
    logic [7:0]        dout_a, dout_b;
    logic              pend_a, pend_b, pulse_a, pulse_b;

    int total = 0;
    int bad   = 0;

    typedef struct { string nm; int dev; logic [7:0] exp; } rd_t;
    typedef struct { string nm; int i0; logic [7:0] v0; int i1; logic [7:0] v1; } cm_t;
    typedef struct { string nm; int dev; int sel; logic [7:0] exp; } pr_t;

    rd_t rd_q[$];
    cm_t cm_q[$];
    pr_t pr_q[$];

    logic rd_req    = 1'b0;
    logic rd_vld    = 1'b0;
    logic probe_req = 1'b0;

    always #5 clk = ~clk;

    gpu_hw_ctrl_regs_dbuf dut (
        .clk(clk), .rst(rst), .we(we), .addr_in(addr_in), .data_in(data_in),
        .vsync(vsync), .regs_active(active_a), .data_out(dout_a),
        .commit_pending(pend_a), .commit_pulse(pulse_a)
    );

    gpu_hw_ctrl_regs_dbuf #(.BASE_ADDR(20'h00100)) dut_b (
        .clk(clk), .rst(rst), .we(we), .addr_in(addr_in), .data_in(data_in),
        .vsync(vsync), .regs_active(active_b), .data_out(dout_b),
        .commit_pending(pend_b), .commit_pulse(pulse_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] probe_val(input pr_t p);
        logic [31:0] v;
        if (p.dev == 0) begin
            if (p.sel == -1)      v = 32'(pend_a);
            else if (p.sel == -2) v = 32'(pulse_a);
            else                  v = 32'(active_a[p.sel]);
        end else begin
            if (p.sel == -1)      v = 32'(pend_b);
            else if (p.sel == -2) v = 32'(pulse_b);
            else                  v = 32'(active_b[p.sel]);
        end
        return v;
    endfunction

    // Read results appear one cycle after the address is presented.
    always @(posedge clk) rd_vld <= rd_req;

    // Monitor: all DUT sampling happens on the falling edge.
    always @(negedge clk) begin
        rd_t r;
        cm_t c;
        pr_t p;
        if (rd_vld) begin
            if (rd_q.size() == 0) begin
                chk("rd_underflow", 32'(rd_q.size()), 32'd1);
            end else begin
                r = rd_q.pop_front();
                chk(r.nm, 32'((r.dev == 0) ? dout_a : dout_b), 32'(r.exp));
            end
        end
        if (pulse_a === 1'b1) begin
            if (cm_q.size() == 0) begin
                chk("unexpected_commit_a", 32'(pulse_a), 32'd0);
            end else begin
                c = cm_q.pop_front();
                chk({c.nm, "_r0"}, 32'(active_a[c.i0]), 32'(c.v0));
                chk({c.nm, "_r1"}, 32'(active_a[c.i1]), 32'(c.v1));
            end
        end
        if (pulse_b === 1'b1) chk("unexpected_commit_b", 32'(pulse_b), 32'd0);
        if (probe_req) begin
            while (pr_q.size() > 0) begin
                p = pr_q.pop_front();
                chk(p.nm, probe_val(p), 32'(p.exp));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [19:0] a, input logic [7:0] d);
        we = 1'b1; addr_in = a; data_in = d;
        tick();
        we = 1'b0;
    endtask

    task automatic rd(input int dev, input logic [19:0] a, input logic [7:0] e, input string nm);
        rd_t t;
        t.nm = nm; t.dev = dev; t.exp = e;
        rd_q.push_back(t);
        addr_in = a; rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
    endtask

    task automatic pr(input string nm, input int dev, input int sel, input logic [7:0] e);
        pr_t t;
        t.nm = nm; t.dev = dev; t.sel = sel; t.exp = e;
        pr_q.push_back(t);
    endtask

    task automatic probe_go;
        probe_req = 1'b1;
        tick();
        probe_req = 1'b0;
    endtask

    task automatic exp_commit(input string nm, input int i0, input logic [7:0] v0,
                              input int i1, input logic [7:0] v1);
        cm_t t;
        t.nm = nm; t.i0 = i0; t.v0 = v0; t.i1 = i1; t.v1 = v1;
        cm_q.push_back(t);
    endtask

    initial begin
        // Reset state
        tick(); tick(); tick();
        rst = 1'b0;
        pr("rst_act0", 0, 0, 8'h01);
        pr("rst_act31", 0, 31, 8'h20);
        pr("rst_act32", 0, 32, 8'h00);
        pr("rst_ctrl_slot", 0, 255, 8'h00);
        pr("rst_pending", 0, -1, 8'h00);
        pr("rst_b_act0", 1, 0, 8'h01);
        probe_go();
        rd(0, 20'h00005, 8'h06, "rst_rd5");
        rd(0, 20'h0001F, 8'h20, "rst_rd31");

        // Staging into shadow, then armed commit on vsync
        wr(20'h00003, 8'hAA);
        pr("stage_act3_held", 0, 3, 8'h04);
        probe_go();
        rd(0, 20'h00003, 8'hAA, "stage_rd_shadow3");
        wr(20'h000FF, 8'h01);
        pr("stage_pending", 0, -1, 8'h01);
        probe_go();
        rd(0, 20'h000FF, 8'h01, "stage_rd_ctrl");
        exp_commit("stage", 3, 8'hAA, 5, 8'h06);
        vsync = 1'b1;
        tick();
        pr("stage_pulse", 0, -2, 8'h01);
        probe_go();
        vsync = 1'b0;
        tick();
        pr("stage_pending_clr", 0, -1, 8'h00);
        probe_go();

        // vsync with nothing armed
        wr(20'h00003, 8'h11);
        vsync = 1'b1; tick(); vsync = 1'b0; tick();
        vsync = 1'b1; tick(); vsync = 1'b0; tick();
        pr("vsonly_act3", 0, 3, 8'hAA);
        pr("vsonly_act0", 0, 0, 8'h01);
        probe_go();

        // Shadow write colliding with the commit edge
        wr(20'h000FF, 8'h01);
        exp_commit("collide", 7, 8'h08, 3, 8'h11);
        vsync = 1'b1; we = 1'b1; addr_in = 20'h00007; data_in = 8'h55;
        tick();
        we = 1'b0;
        pr("collide_pulse", 0, -2, 8'h01);
        probe_go();
        vsync = 1'b0;
        rd(0, 20'h00007, 8'h55, "collide_rd_shadow7");
        rd(0, 20'h000FF, 8'h00, "collide_rd_ctrl");
        pr("collide_act7", 0, 7, 8'h08);
        probe_go();

        // Arm write on the commit edge keeps the FSM armed
        wr(20'h000FF, 8'h01);
        exp_commit("armwin", 7, 8'h55, 3, 8'h11);
        vsync = 1'b1; we = 1'b1; addr_in = 20'h000FF; data_in = 8'h01;
        tick();
        we = 1'b0; vsync = 1'b0;
        pr("armwin_pending", 0, -1, 8'h01);
        probe_go();

        // Repeated arm writes produce only one commit
        wr(20'h000FF, 8'h01);
        wr(20'h00009, 8'h99);
        exp_commit("rearm", 9, 8'h99, 7, 8'h55);
        vsync = 1'b1; tick(); tick();
        vsync = 1'b0; tick();
        pr("rearm_pending", 0, -1, 8'h00);
        pr("rearm_act9", 0, 9, 8'h99);
        probe_go();

        // Immediate commit without vsync
        wr(20'h00002, 8'h22);
        exp_commit("imm", 2, 8'h22, 9, 8'h99);
        wr(20'h000FF, 8'h02);
        pr("imm_pulse", 0, -2, 8'h01);
        probe_go();
        pr("imm_pulse_once", 0, -2, 8'h00);
        pr("imm_pending", 0, -1, 8'h00);
        pr("imm_act2", 0, 2, 8'h22);
        probe_go();

        // Reset discards an armed commit and restores both banks
        wr(20'h000FF, 8'h01);
        wr(20'h00004, 8'h44);
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        pr("rstarm_pending", 0, -1, 8'h00);
        pr("rstarm_act7", 0, 7, 8'h08);
        probe_go();
        rd(0, 20'h00004, 8'h05, "rstarm_rd4");
        vsync = 1'b1; tick(); vsync = 1'b0; tick(); tick();

        // Address decode against base 0x100
        wr(20'h00203, 8'h77);
        rd(1, 20'h00203, 8'h00, "dec_b_rd_miss");
        rd(1, 20'h00103, 8'h04, "dec_b_rd_hit3");
        rd(1, 20'h001FF, 8'h00, "dec_b_rd_ctrl");
        rd(0, 20'h00203, 8'h00, "dec_a_rd_miss");
        rd(0, 20'h00003, 8'h04, "dec_a_rd3");
        pr("dec_b_act3", 1, 3, 8'h04);
        pr("dec_a_act3", 0, 3, 8'h04);
        probe_go();

        tick(); tick();
        chk("rd_q_left", 32'(rd_q.size()), 32'd0);
        chk("commit_q_left", 32'(cm_q.size()), 32'd0);
        chk("probe_q_left", 32'(pr_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
